// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and default widths for the write-back selector
package wb_pkg;

    typedef enum logic {
        WB_FIXED = 1'b0,
        WB_RR    = 1'b1
    } wb_mode_e;

    localparam int W_DEF  = 8;
    localparam int AW_DEF = 3;
    localparam int CW_DEF = 16;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational first-set-bit finder starting at a pointer, with wrap
module rr_pick #(
    parameter int N  = 4,
    parameter int SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic          found,
    output logic [SW-1:0] idx
);

    localparam logic [SW:0] NV = (SW+1)'(N);

    logic [SW:0]   sum;
    logic [SW-1:0] j;

    // Scan from the farthest offset down so the nearest request at or above ptr wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        sum   = '0;
        j     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (SW+1)'(k);
            if (sum >= NV) begin
                sum = sum - NV;
            end
            j = sum[SW-1:0];
            if (req[j]) begin
                found = 1'b1;
                idx   = j;
            end
        end
    end

endmodule

// File: rtl/wb_select_pipe.sv
// rtl/wb_select_pipe.sv - selects one write-back source per cycle and registers the
// register-file write port; fixed-select or round-robin arbitration.
module wb_select_pipe
    import wb_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int N  = 4,
    parameter int AW = AW_DEF,
    parameter int CW = CW_DEF,
    localparam int SW = $clog2(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mode,
    input  logic [SW-1:0]   select,
    input  logic            stall,
    input  logic [N-1:0]    src_valid,
    input  logic [N*AW-1:0] src_addr,
    input  logic [N*W-1:0]  src_data,
    output logic [N-1:0]    gnt,
    output logic            wb_en,
    output logic [AW-1:0]   wb_addr,
    output logic [W-1:0]    wb_data,
    output logic [SW-1:0]   rr_ptr,
    output logic [CW-1:0]   wb_count
);

    localparam logic [SW:0]   NV   = (SW+1)'(N);
    localparam logic [SW-1:0] LAST = SW'(N - 1);

    wb_mode_e      cur_mode;
    logic          rr_found;
    logic [SW-1:0] rr_idx;
    logic          sel_ok;
    logic          win_found;
    logic [SW-1:0] win;
    logic          grant;
    logic [SW-1:0] next_ptr;

    assign cur_mode = wb_mode_e'(mode);

    rr_pick #(
        .N  (N),
        .SW (SW)
    ) u_rr_pick (
        .req   (src_valid),
        .ptr   (rr_ptr),
        .found (rr_found),
        .idx   (rr_idx)
    );

    // An out-of-range select disables both modes, not only fixed selection.
    always_comb begin
        sel_ok    = ({1'b0, select} < NV);
        win       = select;
        win_found = 1'b0;
        if (sel_ok) begin
            if (cur_mode == WB_RR) begin
                win       = rr_idx;
                win_found = rr_found;
            end else begin
                win_found = src_valid[select];
            end
        end
        grant = win_found && !stall && !reset;
        gnt   = '0;
        if (grant) begin
            gnt[win] = 1'b1;
        end
        next_ptr = (win == LAST) ? '0 : win + SW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_en    <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
            rr_ptr   <= '0;
            wb_count <= '0;
        end else if (grant) begin
            wb_en    <= 1'b1;
            wb_addr  <= src_addr[win*AW +: AW];
            wb_data  <= src_data[win*W +: W];
            wb_count <= (&wb_count) ? wb_count : wb_count + CW'(1);
            if (cur_mode == WB_RR) begin
                rr_ptr <= next_ptr;
            end
        end else begin
            wb_en <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_select_pipe.sv
// tb/tb_wb_select_pipe.sv - randomized and directed bench for wb_select_pipe
module tb_wb_select_pipe;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int AW = 3;
    localparam int CW = 4;
    localparam int SW = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic            clk;
    logic            reset;
    logic            mode;
    logic [SW-1:0]   select;
    logic            stall;
    logic [N-1:0]    src_valid;
    logic [N*AW-1:0] src_addr;
    logic [N*W-1:0]  src_data;
    logic [N-1:0]    gnt;
    logic            wb_en;
    logic [AW-1:0]   wb_addr;
    logic [W-1:0]    wb_data;
    logic [SW-1:0]   rr_ptr;
    logic [CW-1:0]   wb_count;

    int checks = 0;
    int errors = 0;

    int m_en, m_addr, m_data, m_ptr, m_count;

    wb_select_pipe #(.W(W), .N(N), .AW(AW), .CW(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .select    (select),
        .stall     (stall),
        .src_valid (src_valid),
        .src_addr  (src_addr),
        .src_data  (src_data),
        .gnt       (gnt),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .rr_ptr    (rr_ptr),
        .wb_count  (wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_en = 0; m_addr = 0; m_data = 0; m_ptr = 0; m_count = 0;
    endtask

    function automatic void model_pick(output bit has, output int w);
        has = 0;
        w   = 0;
        if (int'(select) >= N) return;
        if (mode == 1'b0) begin
            if (src_valid[select]) begin
                has = 1;
                w   = int'(select);
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (src_valid[i]) begin
                    has = 1;
                    w   = i;
                    break;
                end
            end
        end
    endfunction

    task automatic set_src(input int i, input int a, input int d);
        src_addr[i*AW +: AW] = AW'(a);
        src_data[i*W +: W]   = W'(d);
    endtask

    // Compare everything at the falling edge, then advance the model past the rising edge.
    task automatic run_cycle();
        bit has;
        int w;
        int exp_gnt;
        @(negedge clk);
        model_pick(has, w);
        exp_gnt = (has && !stall) ? (1 << w) : 0;
        check("gnt", 32'(gnt), 32'(exp_gnt));
        check("wb_en", 32'(wb_en), 32'(m_en));
        check("wb_addr", 32'(wb_addr), 32'(m_addr));
        check("wb_data", 32'(wb_data), 32'(m_data));
        check("rr_ptr", 32'(rr_ptr), 32'(m_ptr));
        check("wb_count", 32'(wb_count), 32'(m_count));
        if (has && !stall) begin
            m_en    = 1;
            m_addr  = int'(src_addr[w*AW +: AW]);
            m_data  = int'(src_data[w*W +: W]);
            m_count = (m_count == CMAX) ? CMAX : m_count + 1;
            if (mode == 1'b1) m_ptr = (w + 1) % N;
        end else begin
            m_en = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"}, 32'(gnt), 32'd0);
        check({tag, "_en"}, 32'(wb_en), 32'd0);
        check({tag, "_addr"}, 32'(wb_addr), 32'd0);
        check({tag, "_data"}, 32'(wb_data), 32'd0);
        check({tag, "_ptr"}, 32'(rr_ptr), 32'd0);
        check({tag, "_cnt"}, 32'(wb_count), 32'd0);
    endtask

    // Reset pulse placed between clock edges; deassert just after a rising edge.
    task automatic async_reset(input string tag);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero(tag);
        @(posedge clk);
        #1;
        check_all_zero({tag, "_hold"});
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        reset = 1'b1; mode = 1'b1; select = '0; stall = 1'b0;
        src_valid = 4'b1111; src_addr = '0; src_data = '0;
        for (int i = 0; i < N; i++) set_src(i, i + 4, 8'h10 + i);
        model_reset();
        #3;
        check_all_zero("rst");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // First grant after release goes to source 0.
        run_cycle();
        check("rst_first_addr", 32'(wb_addr), 32'd4);

        // Reset mid-write clears wb_en without a clock edge.
        async_reset("rst_mid");

        // Fixed select hit, then miss that must hold data.
        mode = 1'b0; select = 2'd2; src_valid = 4'b0100;
        set_src(2, 3, 8'hA5);
        run_cycle();
        run_cycle();
        check("fix_data", 32'(wb_data), 32'hA5);
        select = 2'd1; src_valid = 4'b1000;
        run_cycle();
        run_cycle();
        check("fix_miss_data", 32'(wb_data), 32'hA5);
        check("fix_ptr", 32'(rr_ptr), 32'd0);

        // Round-robin fairness from a clean pointer.
        async_reset("rst_rr");
        mode = 1'b1; src_valid = 4'b1111;
        for (int i = 0; i < 6; i++) run_cycle();
        check("rr_count6", 32'(wb_count), 32'd6);
        check("rr_ptr6", 32'(rr_ptr), 32'd2);

        // Stall holds the only requester; it wins once stall drops.
        src_valid = 4'b0010; stall = 1'b1;
        run_cycle();
        run_cycle();
        stall = 1'b0;
        run_cycle();
        src_valid = 4'b0000;
        run_cycle();
        check("stall_ptr", 32'(rr_ptr), 32'd2);

        // Counter saturation.
        src_valid = 4'b1111;
        for (int i = 0; i < 20; i++) run_cycle();
        check("sat_count", 32'(wb_count), 32'(CMAX));
        check("sat_en", 32'(wb_en), 32'd1);

        // Randomized traffic with occasional resets.
        async_reset("rst_rand");
        for (int c = 0; c < 400; c++) begin
            mode      = 1'($urandom_range(0, 1));
            stall     = ($urandom_range(0, 4) == 0);
            select    = SW'($urandom_range(0, N - 1));
            src_valid = N'($urandom);
            for (int i = 0; i < N; i++) set_src(i, $urandom, $urandom);
            if ($urandom_range(0, 59) == 0) async_reset("rst_r");
            run_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_select_pipe.md
# wb_select_pipe

Parametrised write-back selector for the register-file write port; successor to the fixed 4:1 write-data mux. It accepts up to N write-back sources, each with a valid, a destination address and data. It picks one per cycle, either by explicit select or by round-robin, and drives a registered write strobe, address and data into the register file. It also supports stall hold, one-hot grant handshaking and a saturating write counter. It sits between execute/memory result producers and the register file.

## Interface
- W, 8, data width of each source and of the write port
- N, 4, number of write-back sources (2..16)
- AW, 3, register address width
- SW, $clog2(N), select/pointer width (derived, not overridden)
- CW, 16, write-counter width
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- mode  in  1  0 = WB_FIXED (select-driven), 1 = WB_RR (round-robin)
- select  in  SW  source index used in WB_FIXED
- stall  in  1  pipeline hold; blocks all grants while high
- src_valid  in  N  per-source write request, level, held until granted
- src_addr  in  N*AW  packed destination addresses, source i at [i*AW +: AW]
- src_data  in  N*W  packed data, source i at [i*W +: W]
- gnt  out  N  one-hot combinational grant; at most one bit high
- wb_en  out  1  registered register-file write enable
- wb_addr  out  AW  registered write address
- wb_data  out  W  registered write data
- rr_ptr  out  SW  current round-robin priority pointer (debug)
- wb_count  out  CW  saturating count of completed writes

## Operation
- Winner selection is combinational each cycle:
  - WB_FIXED: winner = select if src_valid[select]; otherwise no winner, even when other sources are valid.
  - WB_RR: winner = first i with src_valid[i], scanning from rr_ptr upward with wrap N-1 -> 0.
  - Either mode: select >= N yields no winner.
- gnt[winner] = 1 iff a winner exists and stall = 0; else gnt = 0.
- A source is consumed in the cycle its gnt bit is high. The source drops or changes its request on the next cycle; otherwise it is re-arbitrated.
- On clk edge with a grant:
  - wb_en <= 1; wb_addr and wb_data <= the winner's fields.
  - wb_count <= wb_count + 1, saturating at 2^CW - 1.
  - In WB_RR only: rr_ptr <= (winner + 1) mod N.
- On clk edge without a grant (no valid source, or stall): wb_en <= 0; wb_addr, wb_data, rr_ptr and wb_count hold.
- rr_ptr never changes in WB_FIXED. A mode switch takes effect in the same cycle, and a retained rr_ptr is used on return to WB_RR.
- No combinational path from src_* to wb_*. The only combinational outputs are gnt, which depends on src_valid, select, mode, stall and rr_ptr.

## Timing
- Latency: a grant in cycle t gives wb_en = 1 with data in cycle t+1. Sustained throughput is 1 write per cycle.
- Reset values: wb_en 0, wb_addr 0, wb_data 0, rr_ptr 0, wb_count 0. gnt is 0 while reset is high.
- Reset asserted mid-write clears wb_en in the same cycle, asynchronously. The first grant is possible in the first cycle after deassertion.
- stall rising while a source is valid: no gnt that cycle, and wb_en = 0 next cycle. After stall falls, the same source wins (rr_ptr unchanged).
- rr_ptr wrap: a winner at N-1 sets rr_ptr to 0.
- wb_count at maximum stays at maximum; wb_en is unaffected.

## Structure
- Package wb_pkg: enum wb_mode_e {WB_FIXED=0, WB_RR=1}; default constants for W, AW, CW.
- Sub-module rr_pick (N, SW): takes a request vector and a pointer, and returns found plus the index of the first set bit at or above the pointer, with wrap. It is purely combinational and reusable for other arbiters.
- Top level: mode/select gating, the output register, rr_ptr and wb_count flops.

## Test plan
- Reset: reset pulse asynchronous to clk with src_valid = 4'b1111 -> all outputs 0 during reset, gnt = 0; first edge after release in WB_RR -> gnt = 4'b0001, then wb_addr = src_addr[0].
- Fixed mode: mode = 0, select = 2, src_valid = 4'b0100, src_data[2] = 8'hA5, src_addr[2] = 3 -> gnt = 4'b0100; next cycle wb_en = 1, wb_addr = 3, wb_data = A5, rr_ptr stays 0.
- Fixed mode miss: select = 1, src_valid = 4'b1000 -> gnt = 0, wb_en = 0 next cycle, wb_data holds its previous value.
- Round-robin fairness: mode = 1, src_valid = 4'b1111 held for 6 cycles -> grants 0, 1, 2, 3, 0, 1; rr_ptr sequence 1, 2, 3, 0, 1, 2; wb_count = 6.
- Stall: WB_RR, src_valid = 4'b0010, stall high for 2 cycles -> gnt = 0 and wb_en = 0 for 2 cycles, rr_ptr unchanged; stall low -> gnt = 4'b0010, write follows 1 cycle later.
- Counter saturation: CW = 4, 20 consecutive grants -> wb_count stops at 15, wb_en still pulses every cycle.
